// File: rtl/vsub_fp16_seq_if.sv
// Operand/result bundle between the ALU sequencer and the sequential FP16 vector subtract unit.
// The sequencer is the master and the subtract unit is the slave.
interface vsub_fp16_seq_if #(
    parameter int W = 256
);
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;

    modport master (output start, op_a, op_b, input busy, done, diff);
    modport slave  (input start, op_a, op_b, output busy, done, diff);
endinterface

// File: rtl/vsub_fp16_seq.sv
// Sequential FP16 vector subtract: one lane per cycle through a shared datapath.
// Define VSUB_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.
module vsub_fp16_seq #(
    parameter int LANES    = 16,
    parameter int LANE_W   = 16,
    parameter int EXP_BIAS = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    vsub_fp16_seq_if.slave  bus
);
    localparam int LANE_AW = $clog2(LANES);
    localparam logic [LANE_AW-1:0] LAST_LANE = LANE_AW'(LANES - 1);
    localparam logic signed [6:0] EXP_MAX = 7'(2 * EXP_BIAS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [LANE_AW-1:0]      lane_q, lane_d;
    logic [LANES*LANE_W-1:0] a_q, a_d;
    logic [LANES*LANE_W-1:0] b_q, b_d;
    logic [LANES*LANE_W-1:0] diff_q, diff_d;
    logic [LANE_W-1:0]       lane_res;

    // a - b on one lane: b's sign is flipped and a signed-magnitude add follows.
    function automatic logic [15:0] sub_lane(input logic [15:0] a, input logic [15:0] b);
        logic               sa, sb, s_big, s_sml;
        logic [4:0]         ea, eb, e_big, e_sml, ediff;
        logic [13:0]        ma, mb, m_big, m_sml, m_shf, norm;
        logic [14:0]        sum;
        logic [9:0]         mant;
        logic signed [6:0]  e_res;
`ifdef VSUB_ROUND_NEAREST_EN
        logic [10:0]        m_rnd;
`endif
        sa    = a[15];
        sb    = ~b[15];
        ea    = a[14:10];
        eb    = b[14:10];
        ma    = (ea == 5'd0) ? 14'd0 : {1'b1, a[9:0], 3'b000};
        mb    = (eb == 5'd0) ? 14'd0 : {1'b1, b[9:0], 3'b000};
        s_big = sa;  s_sml = sb;
        e_big = ea;  e_sml = eb;
        m_big = ma;  m_sml = mb;
        m_shf = 14'd0;
        norm  = 14'd0;
        if (ea == 5'h1F || eb == 5'h1F)
            return 16'h7E00;
        if ({eb, mb} > {ea, ma}) begin
            s_big = sb;  s_sml = sa;
            e_big = eb;  e_sml = ea;
            m_big = mb;  m_sml = ma;
        end
        ediff = e_big - e_sml;
        // Bits shifted past the sticky position collapse into sticky.
        if (ediff >= 5'd14) begin
            m_shf = {13'd0, |m_sml};
        end else begin
            m_shf    = m_sml >> ediff;
            m_shf[0] = m_shf[0] | (|(m_sml & ((14'h1 << ediff) - 14'h1)));
        end
        if (s_big == s_sml)
            sum = {1'b0, m_big} + {1'b0, m_shf};
        else
            sum = {1'b0, m_big} - {1'b0, m_shf};
        if (sum == 15'd0)
            return 16'h0000;
        e_res = signed'({2'b00, e_big});
        if (sum[14]) begin
            norm    = sum[14:1];
            norm[0] = norm[0] | sum[0];
            e_res   = e_res + 7'sd1;
        end else begin
            norm = sum[13:0];
            for (int i = 0; i < 13; i++) begin
                if (!norm[13]) begin
                    norm  = norm << 1;
                    e_res = e_res - 7'sd1;
                end
            end
        end
        mant = norm[12:3];
`ifdef VSUB_ROUND_NEAREST_EN
        m_rnd = {1'b0, mant};
        if (norm[2] && (norm[1] || norm[0] || norm[3]))
            m_rnd = m_rnd + 11'd1;
        if (m_rnd[10])
            e_res = e_res + 7'sd1;
        mant = m_rnd[9:0];
`endif
        if (e_res >= EXP_MAX)
            return {s_big, 5'h1F, 10'h000};
        if (e_res <= 7'sd0)
            return {s_big, 15'h0000};
        return {s_big, e_res[4:0], mant};
    endfunction

    always_comb begin
        lane_res = sub_lane(a_q[LANE_W*lane_q +: LANE_W], b_q[LANE_W*lane_q +: LANE_W]);
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    lane_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                diff_d[LANE_W*lane_q +: LANE_W] = lane_res;
                if (lane_q == LAST_LANE) begin
                    lane_d  = '0;
                    state_d = S_DONE;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
        end
    end

    assign bus.busy = (state_q == S_RUN) || (state_q == S_DONE);
    assign bus.done = (state_q == S_DONE);
    assign bus.diff = diff_q;
endmodule

// File: tb/tb_vsub_fp16_seq.sv
// Directed scoreboard bench for vsub_fp16_seq: expected vectors are queued at start
// and compared lane by lane when done pulses.
module tb_vsub_fp16_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [255:0] expQ[$];
    logic [255:0] prevDiff;
    logic [255:0] va, vb, ve;

    vsub_fp16_seq_if #(.W(256)) bus_if ();

    vsub_fp16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called right after a negedge; start is sampled on the following posedge.
    task automatic applyStimulus(input logic [255:0] a, input logic [255:0] b, input logic [255:0] expv);
        bus_if.op_a  = a;
        bus_if.op_b  = b;
        bus_if.start = 1'b1;
        expQ.push_back(expv);
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic waitDone(input bit intrude);
        int cnt;
        logic [255:0] expv;
        cnt = 0;
        while (1) begin
            @(negedge clk);
            cnt++;
            if (intrude && (cnt == 5 || cnt == 10)) begin
                bus_if.op_a  = ~bus_if.op_a;
                bus_if.op_b  = bus_if.op_b ^ {16{16'h1234}};
                bus_if.start = 1'b1;
            end else begin
                bus_if.start = 1'b0;
            end
            if (cnt == 8) begin
                checkOutput("busyMidRun", 256'(bus_if.busy), 256'(1'b1));
                checkOutput("lane15Held", 256'(bus_if.diff[255:240]), 256'(prevDiff[255:240]));
            end
            if (bus_if.done === 1'b1 || cnt > 40) break;
        end
        bus_if.start = 1'b0;
        checkOutput("doneLatency", 256'(cnt), 256'(16));
        if (expQ.size() == 0) begin
            checkOutput("scoreboardEmpty", 256'(0), 256'(1));
            expv = '0;
        end else begin
            expv = expQ.pop_front();
        end
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("lane%0d", i), 256'(bus_if.diff[16*i +: 16]), 256'(expv[16*i +: 16]));
        prevDiff = expv;
        @(negedge clk);
        checkOutput("donePulseWidth", 256'(bus_if.done), 256'(1'b0));
        checkOutput("busyAfterDone", 256'(bus_if.busy), 256'(1'b0));
        checkOutput("diffHeld", bus_if.diff, expv);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        prevDiff     = '0;
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.op_a  = '0;
        bus_if.op_b  = '0;
        repeat (2) @(negedge clk);
        checkOutput("resetBusy", 256'(bus_if.busy), 256'(1'b0));
        checkOutput("resetDone", 256'(bus_if.done), 256'(1'b0));
        checkOutput("resetDiff", bus_if.diff, 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] equal operands");
        applyStimulus({16{16'h3C00}}, {16{16'h3C00}}, '0);
        waitDone(1'b0);

        $display("[TB] mixed lanes");
        va = '0; vb = '0; ve = '0;
        va[15:0]  = 16'h4000; vb[15:0]  = 16'h3C00; ve[15:0]  = 16'h3C00;
        va[31:16] = 16'h3C00; vb[31:16] = 16'h4000; ve[31:16] = 16'hBC00;
        va[47:32] = 16'h3C00; vb[47:32] = 16'hBC00; ve[47:32] = 16'h4000;
        applyStimulus(va, vb, ve);
        waitDone(1'b0);

        $display("[TB] specials and boundaries");
        va = '0; vb = '0; ve = '0;
        va[15:0]    = 16'h7BFF; vb[15:0]    = 16'hFBFF; ve[15:0]    = 16'h7C00;
        va[31:16]   = 16'h7C00; vb[31:16]   = 16'h3C00; ve[31:16]   = 16'h7E00;
        va[47:32]   = 16'h0001; vb[47:32]   = 16'h0000; ve[47:32]   = 16'h0000;
        va[63:48]   = 16'hC000; vb[63:48]   = 16'h4000; ve[63:48]   = 16'hC400;
        va[79:64]   = 16'h3E00; vb[79:64]   = 16'h3800; ve[79:64]   = 16'h3C00;
        va[95:80]   = 16'h0400; vb[95:80]   = 16'h0200; ve[95:80]   = 16'h0400;
        va[111:96]  = 16'h0400; vb[111:96]  = 16'h0401; ve[111:96]  = 16'h8000;
        va[127:112] = 16'h3C00; vb[127:112] = 16'h0000; ve[127:112] = 16'h3C00;
        va[143:128] = 16'h8000; vb[143:128] = 16'h0000; ve[143:128] = 16'h0000;
        va[159:144] = 16'h3C00; vb[159:144] = 16'h7E00; ve[159:144] = 16'h7E00;
        va[175:160] = 16'hFBFF; vb[175:160] = 16'h7BFF; ve[175:160] = 16'hFC00;
        applyStimulus(va, vb, ve);
        waitDone(1'b0);

        $display("[TB] rounding");
        va = '0; vb = '0; ve = '0;
        va[15:0]  = 16'h3C00; vb[15:0]  = 16'h0C00;
        va[31:16] = 16'h3C00; vb[31:16] = 16'h0400;
        va[47:32] = 16'h3C00; vb[47:32] = 16'h9000; ve[47:32] = 16'h3C00;
        va[63:48] = 16'h3C00; vb[63:48] = 16'h9200;
        va[79:64] = 16'h7BFF; vb[79:64] = 16'hCE00;
`ifdef VSUB_ROUND_NEAREST_EN
        ve[15:0]  = 16'h3C00;
        ve[31:16] = 16'h3C00;
        ve[63:48] = 16'h3C01;
        ve[79:64] = 16'h7C00;
`else
        ve[15:0]  = 16'h3BFF;
        ve[31:16] = 16'h3BFF;
        ve[63:48] = 16'h3C00;
        ve[79:64] = 16'h7BFF;
`endif
        applyStimulus(va, vb, ve);
        waitDone(1'b0);

        $display("[TB] start ignored while busy, then back-to-back start");
        va = '0; vb = '0; ve = '0;
        for (int i = 0; i < 16; i++) begin
            va[16*i +: 16] = 16'h4200;
            vb[16*i +: 16] = 16'h3C00;
            ve[16*i +: 16] = 16'h4000;
        end
        applyStimulus(va, vb, ve);
        waitDone(1'b1);
        applyStimulus({16{16'h3C00}}, {16{16'hBC00}}, {16{16'h4000}});
        waitDone(1'b0);

        $display("[TB] reset during run");
        applyStimulus({16{16'h4400}}, {16{16'h3C00}}, {16{16'h4200}});
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abortBusy", 256'(bus_if.busy), 256'(1'b0));
        checkOutput("abortDone", 256'(bus_if.done), 256'(1'b0));
        checkOutput("abortDiff", bus_if.diff, 256'(0));
        void'(expQ.pop_back());
        prevDiff = '0;
        repeat (2) @(negedge clk);
        checkOutput("abortNoDone", 256'(bus_if.done), 256'(1'b0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abortIdleNoDone", 256'(bus_if.done), 256'(1'b0));
        checkOutput("abortIdleBusy", 256'(bus_if.busy), 256'(1'b0));
        va = '0; vb = '0; ve = '0;
        va[15:0]  = 16'h4000; vb[15:0]  = 16'h3C00; ve[15:0]  = 16'h3C00;
        va[31:16] = 16'h3C00; vb[31:16] = 16'h4000; ve[31:16] = 16'hBC00;
        applyStimulus(va, vb, ve);
        waitDone(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
